// File: rtl/midi_pkg.sv
// Shared MIDI constants, arbiter state encoding and status-byte length decode.
package midi_pkg;

    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END   = 8'hF7;
    localparam logic [7:0] RT_MIN      = 8'hF8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK  = 2'd1,
        ST_SYSEX = 2'd2
    } state_t;

    // Total message length including the status byte; 0 marks a SysEx start.
    function automatic logic [1:0] msg_len(input logic [7:0] status);
        logic [1:0] len;
        if (status == SYSEX_START) begin
            len = 2'd0;
        end else if (status == SYSEX_END || status >= RT_MIN) begin
            len = 2'd1;
        end else if (status[7:4] == 4'hF) begin
            case (status[3:0])
                4'h1, 4'h3: len = 2'd2;
                4'h2:       len = 2'd3;
                default:    len = 2'd1;
            endcase
        end else begin
            case (status[7:4])
                4'hC, 4'hD: len = 2'd2;
                default:    len = 2'd3;
            endcase
        end
        return len;
    endfunction

endpackage

// File: rtl/midi_msg_len.sv
// Combinational classification of one MIDI byte: status, real-time, SysEx start and message length.
module midi_msg_len
    import midi_pkg::*;
(
    input  logic [7:0] status,
    output logic       is_status,
    output logic       is_rt,
    output logic       is_sysex,
    output logic [1:0] len
);

    assign is_status = status[7];
    assign is_rt     = (status >= RT_MIN);
    assign is_sysex  = (status == SYSEX_START);
    assign len       = msg_len(status);

endmodule

// File: rtl/midi_merge_arbiter.sv
// Round-robin merge of four MIDI byte streams into one TX FIFO, locking a source for a whole message.
module midi_merge_arbiter
    import midi_pkg::*;
#(
    parameter int N_SRC        = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int LOCK_TIMEOUT = 4095
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_SRC-1:0]     req,
    input  logic [8*N_SRC-1:0]   data_i,
    output logic [N_SRC-1:0]     ack,
    input  logic                 stb_rd,
    output logic                 stb_wr,
    output logic [7:0]           data_o,
    output logic [1:0]           grant,
    output logic                 busy,
    output logic                 err_drop,
    output logic                 err_timeout
);

    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMR_W = $clog2(LOCK_TIMEOUT + 1);

    state_t             state_r;
    logic [1:0]         rr_r;
    logic [1:0]         grant_r;
    logic [1:0]         remaining_r;
    logic [TMR_W-1:0]   timer_r;
    logic [OCC_W-1:0]   occ_r;
    logic [N_SRC-1:0]   ack_r;
    logic               stb_wr_r;
    logic [7:0]         data_o_r;
    logic               busy_r;
    logic               err_drop_r;
    logic               err_timeout_r;

    logic [N_SRC-1:0]   is_status_s;
    logic [N_SRC-1:0]   is_rt_s;
    logic [N_SRC-1:0]   is_sysex_s;
    logic [1:0]         len_s [N_SRC];

    logic [N_SRC-1:0]   elig_s;
    logic               space_s;
    logic               timeout_s;
    logic               pick_s;
    logic [1:0]         pick_idx_s;
    logic [1:0]         idx_s;
    logic               hit_s;
    logic [7:0]         sel_byte_s;
    logic               sel_status_s;
    logic               sel_rt_s;
    logic               sel_sysex_s;
    logic [1:0]         sel_len_s;
    logic               drop_s;
    logic               wr_s;

    for (genvar g = 0; g < N_SRC; g++) begin : g_dec
        midi_msg_len u_dec (
            .status    (data_i[8*g +: 8]),
            .is_status (is_status_s[g]),
            .is_rt     (is_rt_s[g]),
            .is_sysex  (is_sysex_s[g]),
            .len       (len_s[g])
        );
    end

    // Source selection and accept/drop decision for this cycle.
    always_comb begin
        elig_s     = req & ~ack_r;
        // A write accepted last cycle is not yet counted in occ_r, so reserve its slot.
        space_s    = (({1'b0, occ_r} + {{OCC_W{1'b0}}, stb_wr_r}) < (OCC_W + 1)'(FIFO_DEPTH));
        timeout_s  = (state_r != ST_IDLE) && (timer_r == TMR_W'(LOCK_TIMEOUT - 1));
        pick_s     = 1'b0;
        pick_idx_s = 2'd0;
        idx_s      = 2'd0;
        hit_s      = 1'b0;
        if (state_r == ST_IDLE) begin
            for (int k = 0; k < N_SRC; k++) begin
                idx_s      = rr_r + 2'(k);
                hit_s      = !pick_s && elig_s[idx_s];
                pick_idx_s = hit_s ? idx_s : pick_idx_s;
                pick_s     = pick_s | hit_s;
            end
        end else if (timeout_s) begin
            pick_s = 1'b0;
        end else if (elig_s[grant_r]) begin
            pick_s     = 1'b1;
            pick_idx_s = grant_r;
        end else begin
            // While locked, other sources may only slip in real-time bytes.
            for (int k = 1; k < N_SRC; k++) begin
                idx_s      = grant_r + 2'(k);
                hit_s      = !pick_s && elig_s[idx_s] && is_rt_s[idx_s];
                pick_idx_s = hit_s ? idx_s : pick_idx_s;
                pick_s     = pick_s | hit_s;
            end
        end
        sel_byte_s   = data_i[{pick_idx_s, 3'b000} +: 8];
        sel_status_s = is_status_s[pick_idx_s];
        sel_rt_s     = is_rt_s[pick_idx_s];
        sel_sysex_s  = is_sysex_s[pick_idx_s];
        sel_len_s    = len_s[pick_idx_s];
        drop_s       = pick_s && !sel_status_s && (state_r == ST_IDLE);
        wr_s         = pick_s && !drop_s && space_s;
    end

    // Message-lock FSM, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            rr_r          <= 2'd0;
            grant_r       <= 2'd0;
            remaining_r   <= 2'd0;
            timer_r       <= {TMR_W{1'b0}};
            occ_r         <= {OCC_W{1'b0}};
            ack_r         <= {N_SRC{1'b0}};
            stb_wr_r      <= 1'b0;
            data_o_r      <= 8'h00;
            busy_r        <= 1'b0;
            err_drop_r    <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            ack_r         <= {N_SRC{1'b0}};
            stb_wr_r      <= 1'b0;
            err_drop_r    <= 1'b0;
            err_timeout_r <= 1'b0;
            case ({stb_wr_r, stb_rd})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= (occ_r != {OCC_W{1'b0}}) ? occ_r - OCC_W'(1) : occ_r;
                default: occ_r <= occ_r;
            endcase
            if (state_r != ST_IDLE) begin
                timer_r <= timer_r + TMR_W'(1);
            end
            if (timeout_s) begin
                state_r       <= ST_IDLE;
                busy_r        <= 1'b0;
                err_timeout_r <= 1'b1;
                rr_r          <= grant_r + 2'd1;
                timer_r       <= {TMR_W{1'b0}};
            end else if (drop_s) begin
                ack_r[pick_idx_s] <= 1'b1;
                err_drop_r        <= 1'b1;
            end else if (wr_s) begin
                ack_r[pick_idx_s] <= 1'b1;
                stb_wr_r          <= 1'b1;
                data_o_r          <= sel_byte_s;
                if (sel_rt_s) begin
                    if (state_r == ST_IDLE) begin
                        rr_r <= pick_idx_s + 2'd1;
                    end
                end else if (sel_status_s) begin
                    // Any non-real-time status byte starts a fresh message, even mid-lock.
                    timer_r <= {TMR_W{1'b0}};
                    if (sel_sysex_s) begin
                        state_r <= ST_SYSEX;
                        busy_r  <= 1'b1;
                        grant_r <= pick_idx_s;
                    end else if (sel_len_s == 2'd1) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        rr_r    <= pick_idx_s + 2'd1;
                    end else begin
                        state_r     <= ST_LOCK;
                        busy_r      <= 1'b1;
                        grant_r     <= pick_idx_s;
                        remaining_r <= sel_len_s - 2'd1;
                    end
                end else begin
                    timer_r <= {TMR_W{1'b0}};
                    if (state_r == ST_LOCK) begin
                        if (remaining_r == 2'd1) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            rr_r    <= grant_r + 2'd1;
                        end else begin
                            remaining_r <= remaining_r - 2'd1;
                        end
                    end
                end
            end
        end
    end

    assign ack         = ack_r;
    assign stb_wr      = stb_wr_r;
    assign data_o      = data_o_r;
    assign grant       = grant_r;
    assign busy        = busy_r;
    assign err_drop    = err_drop_r;
    assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_midi_merge_arbiter.sv
// Directed scenarios for the MIDI merge arbiter with a scoreboard of expected FIFO writes.
module tb_midi_merge_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = 4'h0;
    logic [31:0] data_i = 32'h0;
    logic        stb_rd = 1'b0;
    logic [3:0]  ack;
    logic        stb_wr;
    logic [7:0]  data_o;
    logic [1:0]  grant;
    logic        busy;
    logic        err_drop;
    logic        err_timeout;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    int          ack_cnt[4];
    int          base;

    midi_merge_arbiter #(
        .N_SRC        (4),
        .FIFO_DEPTH   (4),
        .LOCK_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .data_i      (data_i),
        .ack         (ack),
        .stb_rd      (stb_rd),
        .stb_wr      (stb_wr),
        .data_o      (data_o),
        .grant       (grant),
        .busy        (busy),
        .err_drop    (err_drop),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Present n bytes (MSB first) on source s, advancing after each ack.
    task automatic send(input int s, input logic [23:0] b, input int n);
        int cnt;
        for (int k = 0; k < n; k++) begin
            req[s] = 1'b1;
            data_i[s*8 +: 8] = b[(23 - 8*k) -: 8];
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (ack[s] !== 1'b1 && cnt < 200);
            if (ack[s] !== 1'b1) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_ack: src%0d byte %0h actual no ack required ack within %0d cycles", s, b[(23 - 8*k) -: 8], cnt);
            end
        end
        req[s] = 1'b0;
    endtask

    task automatic wait_ack(input int s);
        int cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (ack[s] !== 1'b1 && cnt < 200);
        if (ack[s] !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_ack: src%0d actual no ack required ack within %0d cycles", s, cnt);
        end
    endtask

    task automatic wait_wr(input string name);
        int cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (stb_wr !== 1'b1 && cnt < 200);
        if (stb_wr !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: actual no stb_wr required stb_wr within %0d cycles", name, cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
        // Scoreboard monitor: every FIFO write must match the next expected byte.
        fork
            forever begin
                @(negedge clk);
                if (stb_wr === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL wr_unexpected: actual write %0h required no write", data_o);
                    end else begin
                        chk("wr_data", {24'h0, data_o}, {24'h0, exp_q.pop_front()});
                    end
                end
                for (int i = 0; i < 4; i++) if (ack[i] === 1'b1) ack_cnt[i]++;
            end
        join_none

        stb_rd = 1'b1;
        #12;
        chk("reset_outputs", {14'd0, ack, stb_wr, data_o, grant, busy, err_drop, err_timeout}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: single note-on from src0
        exp_q.push_back(8'h90); exp_q.push_back(8'h3C); exp_q.push_back(8'h64);
        base = ack_cnt[0];
        fork
            send(0, 24'h903C64, 3);
            begin
                wait_wr("t1_wr1");
                chk("t1_busy_first", {31'd0, busy}, 32'd1);
                chk("t1_grant", {30'd0, grant}, 32'd0);
                wait_wr("t1_wr2");
                chk("t1_busy_mid", {31'd0, busy}, 32'd1);
                wait_wr("t1_wr3");
                chk("t1_busy_end", {31'd0, busy}, 32'd0);
            end
        join
        @(negedge clk);
        chk("t1_ack_count", ack_cnt[0] - base, 32'd3);

        // 2: two sources contend, rr=1, messages must not interleave
        exp_q.push_back(8'h90); exp_q.push_back(8'h40); exp_q.push_back(8'h7F);
        exp_q.push_back(8'hC0); exp_q.push_back(8'h05);
        fork
            send(1, 24'h90407F, 3);
            send(2, 24'hC00500, 2);
        join
        // rr is now 3, so src3 wins over src0
        exp_q.push_back(8'hFE); exp_q.push_back(8'hF8);
        fork
            send(0, 24'hF80000, 1);
            send(3, 24'hFE0000, 1);
        join
        @(negedge clk);

        // 3: real-time byte from another source slips into a locked message
        exp_q.push_back(8'h90); exp_q.push_back(8'h3C);
        exp_q.push_back(8'hF8); exp_q.push_back(8'h64);
        fork
            send(0, 24'h903C64, 3);
            begin
                wait_ack(0);
                wait_ack(0);
                send(3, 24'hF80000, 1);
            end
        join
        chk("t3_busy_end", {31'd0, busy}, 32'd0);
        @(negedge clk);

        // 4: orphan data byte while idle
        send(2, 24'h3C0000, 1);
        chk("t4_err_drop", {31'd0, err_drop}, 32'd1);
        chk("t4_no_wr", {31'd0, stb_wr}, 32'd0);
        chk("t4_ack2", {28'd0, ack}, 32'h4);
        @(negedge clk);
        chk("t4_err_drop_pulse", {31'd0, err_drop}, 32'd0);
        repeat (4) @(negedge clk);

        // 5: full FIFO blocks accept until one read strobe
        stb_rd = 1'b0;
        exp_q.push_back(8'hF8); exp_q.push_back(8'hF9); exp_q.push_back(8'hFA); exp_q.push_back(8'hFC);
        send(1, 24'hF8F9FA, 3);
        send(1, 24'hFC0000, 1);
        exp_q.push_back(8'h80);
        req[0] = 1'b1;
        data_i[7:0] = 8'h80;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_stall_wr", {31'd0, stb_wr}, 32'd0);
            chk("t5_stall_ack", {31'd0, ack[0]}, 32'd0);
        end
        stb_rd = 1'b1;
        @(negedge clk);
        stb_rd = 1'b0;
        chk("t5_not_yet", {31'd0, stb_wr}, 32'd0);
        @(negedge clk);
        chk("t5_accept_wr", {31'd0, stb_wr}, 32'd1);
        chk("t5_accept_ack", {31'd0, ack[0]}, 32'd1);
        stb_rd = 1'b1;
        exp_q.push_back(8'h3C); exp_q.push_back(8'h00);
        send(0, 24'h3C0000, 2);
        repeat (6) @(negedge clk);

        // 6: lock timeout, next source served, then reset mid-lock
        exp_q.push_back(8'h90);
        send(0, 24'h900000, 1);
        exp_q.push_back(8'h90); exp_q.push_back(8'h40);
        fork
            begin
                repeat (15) @(negedge clk);
                chk("t6_no_timeout_yet", {31'd0, err_timeout}, 32'd0);
                @(negedge clk);
                chk("t6_timeout", {31'd0, err_timeout}, 32'd1);
                chk("t6_busy_released", {31'd0, busy}, 32'd0);
            end
            send(1, 24'h904000, 2);
        join
        chk("t6_busy_src1", {31'd0, busy}, 32'd1);
        chk("t6_grant_src1", {30'd0, grant}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_reset_outputs", {14'd0, ack, stb_wr, data_o, grant, busy, err_drop, err_timeout}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
